// File: rtl/spi_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_result_tx
// Purpose  : SPI mode-0 slave transmitter returning FFT result bytes to the
//            MCU over MISO. sclk/cs are oversampled on the system clock; result
//            bytes are buffered in a FIFO loaded through a valid/ready port.
// Ports    : clk, reset (sync, active-high)
//            sclk, cs (active low), miso        - SPI pins
//            data_in, data_valid, data_ready    - FIFO load handshake
//            tx_pending                         - FIFO non-empty (MCU GPIO)
//            word_sent                          - 1-cycle pulse per full word
//            underflow, clear_flags             - sticky flag and its clear
// Options  : SPI_RESULT_TX_HEADER_EN - first word of every cs transaction is a
//            status header {underflow, count} instead of FIFO data.
// Revision : 1.0 - initial release
// ============================================================================
module spi_result_tx #(
    parameter int                   SPI_WIDTH  = 8,
    parameter int                   FIFO_DEPTH = 16,
    parameter logic [SPI_WIDTH-1:0] FILL_WORD  = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx_pending,
    output logic                 word_sent,
    output logic                 underflow,
    input  logic                 clear_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(SPI_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SPI_WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // Synchronisers: stage 3 exists only for edge detection.
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;

    logic [1:0]           state_q, state_d;
    logic [SPI_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 miso_q, miso_d;
    logic                 word_sent_q, word_sent_d;
    logic                 underflow_q, underflow_d;
    logic                 armed_q, armed_d;
    logic                 full_q, full_d;
    logic                 tx_pending_q, tx_pending_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [SPI_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic w_push, w_pop, w_uf_set;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

`ifdef SPI_RESULT_TX_HEADER_EN
    localparam int          HDR_W   = SPI_WIDTH - 1;
    localparam int unsigned HDR_MAX = (1 << HDR_W) - 1;
    logic             first_q, first_d;
    logic [HDR_W-1:0] w_hdr_cnt;

    always_comb begin
        if (32'(count_q) > HDR_MAX) w_hdr_cnt = '1;
        else                        w_hdr_cnt = HDR_W'(count_q);
    end
`endif

    always_comb begin
        w_sclk_rise = sclk_s2_q & ~sclk_s3_q;
        w_sclk_fall = ~sclk_s2_q & sclk_s3_q;
        w_cs_rise   = cs_s2_q & ~cs_s3_q;
        // A falling cs is only honoured once cs has been seen high after
        // reset, so a transaction already in flight at reset is ignored.
        w_cs_fall   = ~cs_s2_q & cs_s3_q & armed_q;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        word_sent_d = 1'b0;
        armed_d     = armed_q | cs_s2_q;
        w_push      = data_valid & ~full_q;
        w_pop       = 1'b0;
        w_uf_set    = 1'b0;
`ifdef SPI_RESULT_TX_HEADER_EN
        first_d     = first_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    state_d = ST_LOAD;
`ifdef SPI_RESULT_TX_HEADER_EN
                    first_d = 1'b1;
`endif
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
`ifdef SPI_RESULT_TX_HEADER_EN
                if (first_q) begin
                    shift_d = {underflow_q, w_hdr_cnt};
                    first_d = 1'b0;
                end else
`endif
                if (count_q != '0) begin
                    w_pop   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                end else begin
                    shift_d  = FILL_WORD;
                    w_uf_set = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else if (w_sclk_fall) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        word_sent_d = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        shift_d = {shift_q[SPI_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // cs deassertion overrides everything, including a pending load:
        // nothing is popped and no underflow is raised on the way out.
        if (w_cs_rise) begin
            state_d     = ST_IDLE;
            w_pop       = 1'b0;
            w_uf_set    = 1'b0;
            word_sent_d = 1'b0;
        end

        underflow_d = w_uf_set ? 1'b1 : (clear_flags ? 1'b0 : underflow_q);

        wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d       = (count_d == CNT_FULL);
        tx_pending_d = (count_d != '0);

        // MISO is retimed from the shift register so the pin never glitches
        // while the next-state logic settles.
        miso_d = (state_q != ST_IDLE) ? shift_q[SPI_WIDTH-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1_q    <= 1'b0;
            sclk_s2_q    <= 1'b0;
            sclk_s3_q    <= 1'b0;
            cs_s1_q      <= 1'b1;
            cs_s2_q      <= 1'b1;
            cs_s3_q      <= 1'b1;
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            word_sent_q  <= 1'b0;
            underflow_q  <= 1'b0;
            armed_q      <= 1'b0;
            full_q       <= 1'b0;
            tx_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
`ifdef SPI_RESULT_TX_HEADER_EN
            first_q      <= 1'b0;
`endif
        end else begin
            sclk_s1_q    <= sclk;
            sclk_s2_q    <= sclk_s1_q;
            sclk_s3_q    <= sclk_s2_q;
            cs_s1_q      <= cs;
            cs_s2_q      <= cs_s1_q;
            cs_s3_q      <= cs_s2_q;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            word_sent_q  <= word_sent_d;
            underflow_q  <= underflow_d;
            armed_q      <= armed_d;
            full_q       <= full_d;
            tx_pending_q <= tx_pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifdef SPI_RESULT_TX_HEADER_EN
            first_q      <= first_d;
`endif
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_in;
    end

    assign miso       = miso_q;
    assign data_ready = ~full_q;
    assign tx_pending = tx_pending_q;
    assign word_sent  = word_sent_q;
    assign underflow  = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_result_tx
// Purpose  : Directed self-checking bench for spi_result_tx. An MCU model
//            drives mode-0 transactions at sclk = clk/20 and samples MISO on
//            each rising sclk edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_result_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       miso;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx_pending;
    logic       word_sent;
    logic       underflow;
    logic       clear_flags = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int ws_cnt = 0;

    spi_result_tx dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs          (cs),
        .miso        (miso),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .tx_pending  (tx_pending),
        .word_sent   (word_sent),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_sent) ws_cnt <= ws_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Mode-0 master: MISO sampled just before each rising sclk; cs released
    // one clk after the last falling sclk, as a prompt MCU would.
    task automatic spi_xfer(input int nbits, output logic [31:0] rx);
        rx = '0;
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx   = {rx[30:0], miso};
            sclk = 1'b1;
            repeat (10) @(negedge clk);
            sclk = 1'b0;
            if (i != nbits - 1) repeat (10) @(negedge clk);
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    logic [31:0] rx;
    int          ws0;

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        check("rst_miso",       32'(miso),       32'd0);
        check("rst_data_ready", 32'(data_ready), 32'd1);
        check("rst_tx_pending", 32'(tx_pending), 32'd0);
        check("rst_underflow",  32'(underflow),  32'd0);
        check("rst_word_sent",  32'(word_sent),  32'd0);

`ifdef SPI_RESULT_TX_HEADER_EN
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        ws0 = ws_cnt;
        spi_xfer(32, rx);
        check("hdr_rx",        rx,               32'h0311_2233);
        check("hdr_words",     32'(ws_cnt - ws0), 32'd4);
        check("hdr_pending",   32'(tx_pending),   32'd0);
        check("hdr_underflow", 32'(underflow),    32'd0);
`else
        // Single byte.
        push_byte(8'hA5);
        check("one_pending_hi", 32'(tx_pending), 32'd1);
        ws0 = ws_cnt;
        spi_xfer(8, rx);
        check("one_rx",         rx,               32'h0000_00A5);
        check("one_words",      32'(ws_cnt - ws0), 32'd1);
        check("one_pending_lo", 32'(tx_pending),   32'd0);
        check("one_underflow",  32'(underflow),    32'd0);

        // Three back-to-back words in one transaction.
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h56);
        ws0 = ws_cnt;
        spi_xfer(24, rx);
        check("b2b_rx",        rx,               32'h0012_3456);
        check("b2b_words",     32'(ws_cnt - ws0), 32'd3);
        check("b2b_underflow", 32'(underflow),    32'd0);

        // Empty FIFO -> fill word and sticky underflow.
        spi_xfer(8, rx);
        check("uf_rx",      rx,              32'h0000_0000);
        check("uf_flag",    32'(underflow),  32'd1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
        check("uf_cleared", 32'(underflow),  32'd0);

        // Fill to capacity; 17th push (0xFF) must be dropped.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            data_in    = (i == 16) ? 8'hFF : 8'(8'h40 + i);
            data_valid = 1'b1;
        end
        @(negedge clk);
        data_valid = 1'b0;
        check("full_ready",   32'(data_ready), 32'd0);
        check("full_pending", 32'(tx_pending), 32'd1);
        for (int i = 0; i < 16; i++) begin
            spi_xfer(8, rx);
            check($sformatf("drain_%0d", i), rx, 32'(8'h40 + i));
        end
        check("drain_ready",     32'(data_ready), 32'd1);
        check("drain_pending",   32'(tx_pending), 32'd0);
        check("drain_underflow", 32'(underflow),  32'd0);
        spi_xfer(8, rx);
        check("drain_no17_rx", rx,              32'h0000_0000);
        check("drain_no17_uf", 32'(underflow),  32'd1);
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;

        // Partial word is discarded and not re-sent.
        push_byte(8'hF0);
        push_byte(8'h0F);
        ws0 = ws_cnt;
        spi_xfer(4, rx);
        check("abort_rx",    rx,               32'h0000_000F);
        check("abort_words", 32'(ws_cnt - ws0), 32'd0);
        spi_xfer(8, rx);
        check("abort_next",  rx,               32'h0000_000F);
        check("abort_pend",  32'(tx_pending),   32'd0);
        check("abort_uf",    32'(underflow),    32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
